alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Multi-cycle, handshaked, width-parametrised ALU for the NPC execute stage; successor to the combinational alu.
//  Simple ops return in 1 cycle; MUL/DIV/REM ops iterate one bit per cycle.
//  Accepts one operation at a time over valid/ready and holds its result until the consumer takes it.
// PARAMETERS
//  WIDTH    64               operand/result width; must be >= 8 and a power of two
//  SHAMT_W  $clog2(WIDTH)    localparam; shift amount = in_b[SHAMT_W-1:0]
// PORTS
//  clk        in   1      single clock; all state changes on posedge
//  rst_n      in   1      reset, synchronous, active-low
//  in_valid   in   1      request present
//  in_ready   out  1      block can accept; asserted only in IDLE
//  in_op      in   4      opcode (table below)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  flush      in   1      abort current op; takes effect at the next posedge
//  out_valid  out  1      result present
//  out_ready  in   1      consumer takes result
//  out_res    out  WIDTH  result; stable while out_valid && !out_ready
// BEHAVIOUR
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT(signed, 0/1), 9 SLTU,
//   10 MUL(low WIDTH), 11 MULHU(high WIDTH, unsigned), 12 DIV, 13 DIVU, 14 REM, 15 REMU.
//  All arithmetic is modulo 2^WIDTH; ADD/SUB overflow is silently dropped.
//  FSM: IDLE -> (accept: in_valid && in_ready) -> simple op: DONE; ops 10-15: CALC.
//   CALC runs WIDTH iterations with a step counter 0..WIDTH-1; at step WIDTH-1 -> DONE.
//   DONE: out_valid=1; out_valid && out_ready -> IDLE.
//  Latency from the accept edge: simple op, out_valid on the next cycle; iterative op, out_valid after WIDTH+1 cycles.
//  in_ready=0 in CALC and DONE. Throughput is at most one op per 2 cycles.
//  Iterative units: MUL uses shift-add on unsigned magnitudes; DIV uses restoring division.
//   Signed DIV/REM: operate on |a| and |b|. Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
//  Boundary cases (RISC-V semantics):
//   divisor 0: DIV/DIVU -> all ones; REM/REMU -> in_a.
//   signed overflow (a = 100..0, b = all ones): DIV -> a; REM -> 0.
//   Both cases are detected at accept and still take the full WIDTH+1 cycles (fixed latency).
//  Operands and the op are latched at accept; in_a/in_b may change afterwards.
//  flush: any state -> IDLE; out_valid drops; the result is discarded. flush && in_valid in the same cycle: the request is not accepted.
//  Reset (rst_n=0 at posedge): state IDLE, in_ready=1 after release, out_valid=0, out_res=0, step counter 0.
//   Reset mid-CALC or mid-DONE abandons the op; no result is delivered.
//  out_res is registered, never a combinational path from in_*.
// CONFIGURATION
//  ALU_MULDIV_EN defined:   ops 10-15 implemented as above.
//  ALU_MULDIV_EN undefined: no iterative datapath. Ops 10-15 behave as simple ops: 1-cycle latency, out_res=0.
//   CALC state and step counter are not generated.
// STRUCTURE
//  Package alu_pkg: alu_op_e (4-bit opcode enum), alu_state_e {IDLE, CALC, DONE}, ALU_OP_W=4.
//  Sub-module alu_muldiv_iter (WIDTH): start, op, a, b -> done pulse plus result; owns the step counter and the acc/quotient/remainder regs.
//   Instantiated only under ALU_MULDIV_EN.
//  Top alu_mc holds: FSM, the combinational simple-op datapath, the result register, and the handshake.
// TESTING
//  WIDTH=64, op 8 (SLT), a=0xffff_ffff_ffff_fff0, b=0 -> out_res=1 one cycle after accept; op 9 (SLTU) same operands -> 0.
//  op 0, a=0xffff_ffff_ffff_ffff, b=1 -> 0 (wrap); op 7, a=0x8000_0000_0000_0000, b=63 -> all ones.
//  op 10, a=0xffff_ffff_ffff_ffff, b=3 -> 0xffff_ffff_ffff_fffd; op 11 same operands -> 2; out_valid exactly 65 cycles after accept.
//  op 12, a=-7, b=2 -> -3; op 14 same -> -1; op 13, b=0 -> all ones; op 12, a=0x8000..0, b=-1 -> 0x8000..0; op 14 same -> 0.
//  Backpressure: out_ready=0 for 10 cycles in DONE -> out_res stable, in_ready=0; then out_ready=1 -> IDLE; next op accepted the following cycle.
//  flush at CALC step 20 -> no out_valid, in_ready=1 next cycle; rst_n=0 mid-CALC -> same; build without ALU_MULDIV_EN: op 12 -> 0 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by alu_mc; ALU_MULDIV_EN selects the iterative unit
package alu_pkg;
    localparam int ALU_OP_W = 4;
    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_SLT, OP_SLTU, OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } alu_op_e;
    typedef enum logic [1:0] {IDLE, CALC, DONE} alu_state_e;
    function automatic logic is_iter(input alu_op_e op);
        return op >= OP_MUL;
    endfunction
endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response handshake bundle between the execute stage and alu_mc
interface alu_mc_if #(parameter int WIDTH = 64);
    import alu_pkg::*;
    logic             in_valid;
    logic             in_ready;
    alu_op_e          in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    modport master (
        output in_valid, in_op, in_a, in_b, flush, out_ready,
        input  in_ready, out_valid, out_res
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, flush, out_ready,
        output in_ready, out_valid, out_res
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider (used when ALU_MULDIV_EN is defined)
module alu_muldiv_iter import alu_pkg::*; #(parameter int WIDTH = 64) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_flush,
    input  alu_op_e          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_res
);
    localparam int STEP_W = $clog2(WIDTH);
    logic [STEP_W-1:0] r_step;
    logic              r_busy, r_mul, r_sel_hi, r_neg, r_spec;
    logic [WIDTH-1:0]  r_hi, r_lo, r_b, r_spec_val;
    logic              w_mul, w_rem, w_signed, w_b_zero, w_ovf, w_ge;
    logic [WIDTH-1:0]  w_a_mag, w_b_mag, w_sub, w_nhi, w_nlo, w_raw;
    logic [WIDTH:0]    w_sum, w_rem_sh;
    assign w_mul    = i_op == OP_MUL || i_op == OP_MULHU;
    assign w_rem    = i_op == OP_REM || i_op == OP_REMU;
    assign w_signed = i_op == OP_DIV || i_op == OP_REM;
    assign w_a_mag  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_b_zero = i_b == '0;
    assign w_ovf    = w_signed && i_a == {1'b1, {(WIDTH-1){1'b0}}} && &i_b;
    assign w_sum    = {1'b0, r_hi} + {1'b0, r_lo[0] ? r_b : '0};
    assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    assign w_ge     = w_rem_sh >= {1'b0, r_b};
    assign w_sub    = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_nhi    = r_mul ? w_sum[WIDTH:1] : (w_ge ? w_sub : w_rem_sh[WIDTH-1:0]);
    assign w_nlo    = r_mul ? {w_sum[0], r_lo[WIDTH-1:1]} : {r_lo[WIDTH-2:0], w_ge};
    assign w_raw    = r_sel_hi ? w_nhi : w_nlo;
    assign o_res    = r_spec ? r_spec_val : (r_neg ? -w_raw : w_raw);
    assign o_done   = r_busy && &r_step;
    // accept loads magnitudes and the sign/special-case fixups; each busy cycle runs one step
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_busy <= 1'b0;
            r_step <= '0;
        end else if (i_start) begin
            r_busy     <= 1'b1;
            r_step     <= '0;
            r_hi       <= '0;
            r_lo       <= w_mul ? i_a : w_a_mag;
            r_b        <= w_mul ? i_b : w_b_mag;
            r_mul      <= w_mul;
            r_sel_hi   <= i_op == OP_MULHU || w_rem;
            r_neg      <= (i_op == OP_DIV && (i_a[WIDTH-1] ^ i_b[WIDTH-1])) || (i_op == OP_REM && i_a[WIDTH-1]);
            r_spec     <= !w_mul && (w_b_zero || w_ovf);
            r_spec_val <= w_b_zero ? (w_rem ? i_a : '1) : (w_rem ? '0 : i_a);
        end else if (r_busy) begin
            r_hi   <= w_nhi;
            r_lo   <= w_nlo;
            r_step <= r_step + 1'b1;
            if (&r_step) r_busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked multi-cycle ALU; MUL/DIV/REM iterate only when ALU_MULDIV_EN is defined
module alu_mc import alu_pkg::*; #(parameter int WIDTH = 64) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    alu_state_e         r_state;
    logic               r_in_ready, r_out_valid;
    logic [WIDTH-1:0]   r_res, w_simple;
    logic [SHAMT_W-1:0] w_shamt;
    assign w_shamt       = bus.in_b[SHAMT_W-1:0];
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_res   = r_res;
`ifdef ALU_MULDIV_EN
    logic             w_start, w_md_done;
    logic [WIDTH-1:0] w_md_res;
    assign w_start = r_state == IDLE && bus.in_valid && !bus.flush && is_iter(bus.in_op);
    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk(clk), .rst_n(rst_n), .i_start(w_start), .i_flush(bus.flush), .i_op(bus.in_op),
        .i_a(bus.in_a), .i_b(bus.in_b), .o_done(w_md_done), .o_res(w_md_res)
    );
`endif
    // single-cycle datapath; iterative opcodes yield 0 here
    always_comb begin
        w_simple = '0;
        case (bus.in_op)
            OP_ADD:  w_simple = bus.in_a + bus.in_b;
            OP_SUB:  w_simple = bus.in_a - bus.in_b;
            OP_AND:  w_simple = bus.in_a & bus.in_b;
            OP_OR:   w_simple = bus.in_a | bus.in_b;
            OP_XOR:  w_simple = bus.in_a ^ bus.in_b;
            OP_SLL:  w_simple = bus.in_a << w_shamt;
            OP_SRL:  w_simple = bus.in_a >> w_shamt;
            OP_SRA:  w_simple = $signed(bus.in_a) >>> w_shamt;
            OP_SLT:  w_simple = {{(WIDTH-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
            OP_SLTU: w_simple = {{(WIDTH-1){1'b0}}, bus.in_a < bus.in_b};
            default: w_simple = '0;
        endcase
    end
    // control FSM with registered handshake flags and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_res       <= '0;
        end else if (bus.flush) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_in_ready <= 1'b0;
                    r_res      <= w_simple;
`ifdef ALU_MULDIV_EN
                    r_state     <= is_iter(bus.in_op) ? CALC : DONE;
                    r_out_valid <= !is_iter(bus.in_op);
`else
                    r_state     <= DONE;
                    r_out_valid <= 1'b1;
`endif
                end
`ifdef ALU_MULDIV_EN
                CALC: if (w_md_done) begin
                    r_state     <= DONE;
                    r_out_valid <= 1'b1;
                    r_res       <= w_md_res;
                end
`endif
                DONE: if (bus.out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc; expectations follow ALU_MULDIV_EN
module tb_alu_mc;
    import alu_pkg::*;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    typedef struct {
        string       tag;
        logic [63:0] res;
        int          lat;
        time         t;
    } ent_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   seen = 1'b0;
    ent_t sb[$];
    alu_mc_if #(.WIDTH(64)) bus ();
    alu_mc #(.WIDTH(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic signed [63:0] q, r;
        logic z, ovf;
        p = {64'd0, a} * {64'd0, b};
        z = b == 64'd0;
        ovf = a == MIN && b == '1;
        q = '0;
        r = '0;
        if (!z && !ovf) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        case (op)
            4'd0:  model = a + b;
            4'd1:  model = a - b;
            4'd2:  model = a & b;
            4'd3:  model = a | b;
            4'd4:  model = a ^ b;
            4'd5:  model = a << b[5:0];
            4'd6:  model = a >> b[5:0];
            4'd7:  model = $signed(a) >>> b[5:0];
            4'd8:  model = {63'd0, $signed(a) < $signed(b)};
            4'd9:  model = {63'd0, a < b};
            4'd10: model = p[63:0];
            4'd11: model = p[127:64];
            4'd12: model = z ? '1 : (ovf ? a : q);
            4'd13: model = z ? '1 : a / b;
            4'd14: model = z ? a : (ovf ? 64'd0 : r);
            default: model = z ? a : a % b;
        endcase
        if (!MD && op >= 4'd10) model = '0;
    endfunction
    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input string tag, input bit track);
        ent_t e;
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_op = alu_op_e'(op);
        bus.in_a = a;
        bus.in_b = b;
        if (track) begin
            e.tag = tag;
            e.res = model(op, a, b);
            e.lat = (MD && op >= 4'd10) ? 65 : 1;
            e.t = $time + 4;
            sb.push_back(e);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_a = ~a;
        bus.in_b = ~b;
    endtask
    // scoreboard: latency on first out_valid, result on handshake, sampled just before the posedge
    always @(negedge clk) begin
        #4;
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                if (bus.out_ready) chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk({sb[0].tag, "_lat"}, 64'(($time - sb[0].t + 1) / 10), 64'(sb[0].lat));
                end
                if (bus.out_ready) begin
                    chk(sb[0].tag, bus.out_res, sb[0].res);
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end
    initial begin
        logic [63:0] a, b;
        logic [3:0] op;
        int n;
        bus.in_valid = 1'b0;
        bus.in_op = OP_ADD;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_res", bus.out_res, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        send(4'd8, 64'hffff_ffff_ffff_fff0, 64'd0, "slt", 1);
        send(4'd9, 64'hffff_ffff_ffff_fff0, 64'd0, "sltu", 1);
        send(4'd0, '1, 64'd1, "add_wrap", 1);
        send(4'd7, MIN, 64'd63, "sra", 1);
        send(4'd1, 64'd5, 64'd9, "sub", 1);
        send(4'd5, 64'h1234, 64'd68, "sll", 1);
        send(4'd6, MIN, 64'd4, "srl", 1);
        send(4'd4, 64'hf0f0, 64'hff00, "xor", 1);
        send(4'd10, '1, 64'd3, "mul", 1);
        send(4'd11, '1, 64'd3, "mulhu", 1);
        send(4'd12, -64'sd7, 64'd2, "div", 1);
        send(4'd14, -64'sd7, 64'd2, "rem", 1);
        send(4'd13, 64'd12345, 64'd0, "divu_zero", 1);
        send(4'd15, 64'd12345, 64'd0, "remu_zero", 1);
        send(4'd14, -64'sd9, 64'd0, "rem_zero", 1);
        send(4'd12, MIN, '1, "div_ovf", 1);
        send(4'd14, MIN, '1, "rem_ovf", 1);
        send(4'd13, '1, 64'd10, "divu", 1);
        send(4'd15, 64'd100, 64'd7, "remu", 1);
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(0, 15));
            a = {$urandom, $urandom};
            b = (i % 3 == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
            send(op, a, b, "rand", 1);
        end
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        send(4'd0, 64'd40, 64'd2, "bp", 1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_res", bus.out_res, 64'd42);
            chk("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        send(4'd3, 64'h0f, 64'hf0, "bp_next", 1);
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        send(4'd10, 64'd5, 64'd7, "flush_op", 0);
        repeat (20) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        repeat (80) tick();
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op = OP_ADD;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_req_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("flush_req_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;
        send(4'd13, 64'd100, 64'd7, "rst_op", 0);
        repeat (20) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_res", bus.out_res, 64'd0);
        bus.out_ready = 1'b1;
        repeat (80) tick();
        send(4'd12, 64'd100, -64'sd7, "post_rst_div", 1);
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (sb.size() != 0) chk("drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
